load_store_unit: RTL and testbench

Data-memory access stage of the single-cycle RISC-V core. It sits between the ALU (address) and the writeback select, and drives the value presented on the writeback "load result" input (select 001). It converts LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned requests on a valid/ready data-memory port, with byte strobes and load extraction/extension. It stalls the core while a request is outstanding and flags misaligned or illegal accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 access encodings, FSM states
// and the access legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   // Unsigned loads have no store counterpart, so BU/HU are legal only for loads.
   function automatic logic access_ok(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~a[0];
         F3_W:    ok = (a == 2'b00);
         F3_BU:   ok = ~is_store;
         F3_HU:   ok = ~is_store & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half from a read word and sign/zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[7:0];
      case (off_i)
         2'd0:    byte_v = rdata_i[7:0];
         2'd1:    byte_v = rdata_i[15:8];
         2'd2:    byte_v = rdata_i[23:16];
         default: byte_v = rdata_i[31:24];
      endcase
      half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      result_o = rdata_i;
      case (funct3_i)
         F3_B:    result_o = {{24{byte_v[7]}}, byte_v};
         F3_BU:   result_o = {24'd0, byte_v};
         F3_H:    result_o = {{16{half_v[15]}}, half_v};
         F3_HU:   result_o = {16'd0, half_v};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: converts loads/stores into word-aligned valid/ready
// requests, stalls the core while outstanding, and flags faults and timeouts.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_result,
   output logic        stall,
   output logic        fault,
   output logic        bus_error,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata
);

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [2:0]    f3_q, f3_d;
   logic [31:0]   sdata_q, sdata_d;
   logic          we_q, we_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   data_q, data_d;
   logic          err_q, err_d;

   logic [31:0]   align_res;
   logic [3:0]    lane_strb;
   logic [31:0]   lane_wdata;
   logic          is_store;

   assign is_store = mem_write & ~mem_read;

   lsu_load_align u_align (
      .rdata_i  (dmem_rdata),
      .off_i    (addr_q[1:0]),
      .funct3_i (f3_q),
      .result_o (align_res)
   );

   always_comb begin
      lane_strb  = 4'b1111;
      lane_wdata = sdata_q;
      case (f3_q[1:0])
         2'b00: begin
            lane_strb  = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{sdata_q[7:0]}};
         end
         2'b01: begin
            lane_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{sdata_q[15:0]}};
         end
         default: begin
            lane_strb  = 4'b1111;
            lane_wdata = sdata_q;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      f3_d        = f3_q;
      sdata_d     = sdata_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      err_d       = err_q;
      stall       = 1'b0;
      fault       = 1'b0;
      bus_error   = 1'b0;
      load_result = '0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = '0;
      dmem_wdata  = '0;
      dmem_wstrb  = '0;

      case (state_q)
         IDLE: begin
            if (mem_read | mem_write) begin
               if (access_ok(is_store, funct3, addr[1:0])) begin
                  stall   = 1'b1;
                  addr_d  = addr;
                  f3_d    = funct3;
                  sdata_d = store_data;
                  we_d    = is_store;
                  cnt_d   = '0;
                  data_d  = '0;
                  err_d   = 1'b0;
                  state_d = BUSY;
               end else begin
                  fault = 1'b1;
               end
            end
         end
         BUSY: begin
            stall     = 1'b1;
            dmem_req  = 1'b1;
            dmem_we   = we_q;
            dmem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
               dmem_wdata = lane_wdata;
               dmem_wstrb = lane_strb;
            end
            if (dmem_ready) begin
               data_d  = we_q ? '0 : align_res;
               state_d = DONE;
            // cnt_q counts BUSY cycles already spent, so TIMEOUT-1 marks the last one
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            bus_error   = err_q;
            load_result = (we_q | err_q) ? '0 : data_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         sdata_q <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         f3_q    <= f3_d;
         sdata_q <= sdata_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected load results.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [31:0] load_result;
   logic        stall, fault, bus_error;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .funct3      (funct3),
      .addr        (addr),
      .store_data  (store_data),
      .load_result (load_result),
      .stall       (stall),
      .fault       (fault),
      .bus_error   (bus_error),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_wstrb  (dmem_wstrb),
      .dmem_ready  (dmem_ready),
      .dmem_rdata  (dmem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full access with 'waits' wait states; called one time unit after a rising edge.
   task automatic do_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input int unsigned waits,
                            input logic [31:0] rdata, input logic [31:0] exp_res,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      int unsigned stalls;
      logic [31:0] e;
      stalls     = 0;
      mem_read   = rd;
      mem_write  = wr;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      dmem_ready = 1'b0;
      exp_q.push_back(exp_res);
      #1;
      if (stall) stalls++;
      chk({nm, " idle_stall"}, 32'(stall), 32'd1);
      chk({nm, " idle_fault"}, 32'(fault), 32'd0);
      for (int unsigned i = 0; i <= waits; i++) begin
         step();
         dmem_ready = (i == waits);
         dmem_rdata = (i == waits) ? rdata : 32'h5A5A_5A5A;
         #1;
         if (stall) stalls++;
         chk({nm, " busy_req"}, 32'(dmem_req), 32'd1);
         chk({nm, " busy_we"}, 32'(dmem_we), 32'(wr & ~rd));
         chk({nm, " busy_addr"}, dmem_addr, {a[31:2], 2'b00});
         chk({nm, " busy_strb"}, 32'(dmem_wstrb), 32'(exp_strb));
         chk({nm, " busy_lr"}, load_result, 32'd0);
         if (wr & ~rd) chk({nm, " busy_wdata"}, dmem_wdata, exp_wdata);
      end
      step();
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      #1;
      if (stall) stalls++;
      chk({nm, " done_req"}, 32'(dmem_req), 32'd0);
      chk({nm, " done_berr"}, 32'(bus_error), 32'd0);
      if (exp_q.size() == 0) begin
         chk({nm, " sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({nm, " done_lr"}, load_result, e);
      end
      chk({nm, " stall_cycles"}, stalls, 2 + waits);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
      #1;
      chk({nm, " after_lr"}, load_result, 32'd0);
      chk({nm, " after_req"}, 32'(dmem_req), 32'd0);
   endtask

   task automatic do_fault(input string nm, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      #1;
      chk({nm, " fault"}, 32'(fault), 32'd1);
      chk({nm, " stall"}, 32'(stall), 32'd0);
      chk({nm, " req"}, 32'(dmem_req), 32'd0);
      chk({nm, " lr"}, load_result, 32'd0);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      step();
      #1;
      chk({nm, " next_req"}, 32'(dmem_req), 32'd0);
      chk({nm, " next_fault"}, 32'(fault), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'b000;
      addr       = 32'h0;
      store_data = 32'h0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      step();
      step();
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_lr", load_result, 32'd0);
      chk("rst_berr", 32'(bus_error), 32'd0);
      rst = 1'b0;

      step();
      do_access("lw_0x100", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 4'b0000, 32'h0);
      step();
      do_access("lb_0x103", 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h8012_3456,
                32'hFFFF_FF80, 4'b0000, 32'h0);
      step();
      do_access("lbu_0x103", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h8012_3456,
                32'h0000_0080, 4'b0000, 32'h0);
      step();
      do_access("lh_0x102", 1, 0, 3'b001, 32'h102, 32'h0, 3, 32'h8001_0000,
                32'hFFFF_8001, 4'b0000, 32'h0);
      step();
      do_access("lhu_0x100", 1, 0, 3'b101, 32'h100, 32'h0, 0, 32'h1234_F00D,
                32'h0000_F00D, 4'b0000, 32'h0);
      step();
      do_access("sh_0x202", 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 32'hFFFF_FFFF,
                32'h0, 4'b1100, 32'hABCD_ABCD);
      step();
      do_access("sb_0x201", 0, 1, 3'b000, 32'h201, 32'h1234_56A5, 2, 32'hFFFF_FFFF,
                32'h0, 4'b0010, 32'hA5A5_A5A5);
      step();
      do_access("sw_0x204", 1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 32'h0,
                32'h0, 4'b1111, 32'hCAFE_F00D);
      step();
      do_access("both_rd_wins", 1, 1, 3'b010, 32'h208, 32'h1111_1111, 0, 32'h7654_3210,
                32'h7654_3210, 4'b0000, 32'h0);

      step();
      do_fault("lw_mis_0x101", 1, 0, 3'b010, 32'h101);
      do_fault("lh_mis_0x103", 1, 0, 3'b001, 32'h103);
      do_fault("ld_f3_011", 1, 0, 3'b011, 32'h100);
      do_fault("sbu_illegal", 0, 1, 3'b100, 32'h100);

      // ready while idle must not start or complete anything
      dmem_ready = 1'b1;
      #1;
      chk("idle_ready_req", 32'(dmem_req), 32'd0);
      chk("idle_ready_stall", 32'(stall), 32'd0);
      step();
      dmem_ready = 1'b0;
      #1;
      chk("idle_ready_lr", load_result, 32'd0);

      // store timeout
      step();
      mem_write  = 1'b1;
      funct3     = 3'b010;
      addr       = 32'h300;
      store_data = 32'h1122_3344;
      #1;
      chk("to_idle_stall", 32'(stall), 32'd1);
      for (int i = 0; i < 16; i++) begin
         step();
         chk("to_busy_req", 32'(dmem_req), 32'd1);
         chk("to_busy_stall", 32'(stall), 32'd1);
         chk("to_busy_addr", dmem_addr, 32'h300);
         chk("to_busy_wdata", dmem_wdata, 32'h1122_3344);
         chk("to_busy_strb", 32'(dmem_wstrb), 32'hF);
         chk("to_busy_berr", 32'(bus_error), 32'd0);
      end
      step();
      chk("to_done_req", 32'(dmem_req), 32'd0);
      chk("to_done_stall", 32'(stall), 32'd0);
      chk("to_done_berr", 32'(bus_error), 32'd1);
      chk("to_done_lr", load_result, 32'd0);
      mem_write = 1'b0;
      step();
      chk("to_after_berr", 32'(bus_error), 32'd0);

      // reset during an in-flight load
      step();
      mem_read = 1'b1;
      funct3   = 3'b010;
      addr     = 32'h400;
      step();
      chk("rb_busy1_req", 32'(dmem_req), 32'd1);
      step();
      chk("rb_busy2_req", 32'(dmem_req), 32'd1);
      rst      = 1'b1;
      mem_read = 1'b0;
      step();
      chk("rb_req", 32'(dmem_req), 32'd0);
      chk("rb_stall", 32'(stall), 32'd0);
      chk("rb_berr", 32'(bus_error), 32'd0);
      chk("rb_lr", load_result, 32'd0);
      rst = 1'b0;
      step();
      chk("rb_idle_req", 32'(dmem_req), 32'd0);
      chk("rb_idle_lr", load_result, 32'd0);
      do_access("lw_after_rst", 1, 0, 3'b010, 32'h404, 32'h0, 0, 32'h0BAD_F00D,
                32'h0BAD_F00D, 4'b0000, 32'h0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
